// File: rtl/srm_pkg.sv
// Shared encodings for the Simple RISC Machine instruction sequencer:
// FSM states, instruction-class tags, opcode/op values, ALU and writeback
// select codes, and the bit positions of every instruction-register field.
package srm_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        DECODE = 3'd1,
        WR_IMM = 3'd2,
        GET_A  = 3'd3,
        GET_B  = 3'd4,
        ALU    = 3'd5,
        WR_REG = 3'd6
    } state_t;

    // Decoded instruction class; CLS_BAD marks anything unsupported
    typedef enum logic [2:0] {
        CLS_BAD     = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } iclass_t;

    // Opcode field values
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Op field values
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operation codes
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_AND  = 2'b10;
    localparam logic [1:0] ALUOP_NOTB = 2'b11;

    // Writeback source select
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b01;

    // Instruction register field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;
    localparam int IMM_MSB = 7;

endpackage

// File: rtl/srm_controller_instr_dec.sv
// Purely combinational instruction decoder: splits the instruction
// register into its fields, sign-extends the 8-bit immediate and
// classifies the instruction, flagging anything the sequencer cannot run.
module instr_dec
    import srm_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op,
    output logic [15:0] sximm8,
    output iclass_t     cls,
    output logic        legal
);

    logic [2:0] opcode;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign op     = ir[OP_MSB:OP_LSB];
    assign rn     = ir[RN_MSB:RN_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign sh     = ir[SH_MSB:SH_LSB];
    assign rm     = ir[RM_MSB:RM_LSB];

    // Low byte passes straight through; upper byte replicates the imm8 sign bit
    assign sximm8[IMM_MSB:0] = ir[IMM_MSB:0];
    generate
        for (genvar gi = IMM_MSB + 1; gi < 16; gi++) begin : g_sext
            assign sximm8[gi] = ir[IMM_MSB];
        end
    endgenerate

    // Map opcode/op onto an instruction class; unknown encodings stay CLS_BAD
    always_comb begin
        cls = CLS_BAD;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                cls = CLS_MOV_IMM;
            end else if (op == OP_MOV_REG) begin
                cls = CLS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end

    assign legal = (cls != CLS_BAD);

endmodule

// File: rtl/srm_controller.sv
// Instruction sequencer for the Simple RISC Machine datapath. Holds the
// instruction register and steps the register file, operand/result/status
// registers and ALU/shifter through one instruction per start request.
// All control outputs are Moore outputs of the state plus the held IR.
module srm_controller
    import srm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  regnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  aluop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        bad
);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] ir_reg;

    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  op;
    iclass_t     cls;
    logic        legal;

    instr_dec u_dec (
        .ir     (ir_reg),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .op     (op),
        .sximm8 (sximm8),
        .cls    (cls),
        .legal  (legal)
    );

    // State register and instruction register; IR only accepts a new word while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WAIT;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT && load) begin
                ir_reg <= in;
            end
        end
    end

    // Next-state selection and per-state control decode
    always_comb begin
        state_next = state_reg;
        w          = 1'b0;
        regnum     = 3'd0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        vsel       = VSEL_C;
        aluop      = ALUOP_ADD;
        bad        = 1'b0;

        case (state_reg)
            WAIT: begin
                w = 1'b1;
                // A load in the same cycle wins; the start is dropped
                if (s && !load) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                 state_next = WR_IMM;
                    CLS_MOV_REG, CLS_MVN:        state_next = GET_B;
                    CLS_ADD, CLS_AND, CLS_CMP:   state_next = GET_A;
                    default: begin
                        state_next = WAIT;
                        bad        = 1'b1;
                    end
                endcase
            end
            WR_IMM: begin
                regnum     = rn;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                state_next = WAIT;
            end
            GET_A: begin
                regnum     = rn;
                loada      = 1'b1;
                state_next = GET_B;
            end
            GET_B: begin
                regnum     = rm;
                loadb      = 1'b1;
                state_next = ALU;
            end
            ALU: begin
                // MOV reg rides the adder with A forced to zero; MVN ignores A
                aluop = (cls == CLS_MOV_REG) ? ALUOP_ADD : op;
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                if (cls == CLS_CMP) begin
                    loads      = 1'b1;
                    state_next = WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = WR_REG;
                end
            end
            WR_REG: begin
                regnum     = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = WAIT;
            end
            default: begin
                state_next = WAIT;
            end
        endcase
    end

    assign shift = sh;
    assign bsel  = 1'b0;

endmodule

// File: tb/tb_srm_controller.sv
// Self-checking bench for srm_controller: a schedule-based reference model
// turns each started instruction into its list of expected per-cycle
// control vectors; a compare process checks every cycle, and directed
// scenarios pin specific values by hand before a randomized run.
`timescale 1ns/1ps
module tb_srm_controller;

    typedef struct packed {
        logic        w;
        logic [2:0]  regnum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  vsel;
        logic [1:0]  aluop;
        logic        bad;
        logic [1:0]  shift;
        logic [15:0] sximm8;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in_w = 16'h0000;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, bad;
    logic [2:0]  regnum;
    logic [1:0]  vsel, aluop, shift;
    logic [15:0] sximm8;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    srm_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in_w),
        .w(w), .regnum(regnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .aluop(aluop),
        .shift(shift), .sximm8(sximm8), .bad(bad)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_ir = 16'h0000;
    ctl_t        mq[$];     // pending non-idle cycles of the running instruction

    function automatic ctl_t blank();
        ctl_t z;
        z = '0;
        return z;
    endfunction

    // Expand one instruction into the cycles it spends away from idle
    function automatic void schedule(input logic [15:0] ir);
        logic [2:0] opc, rn_f, rd_f, rm_f;
        logic [1:0] op_f;
        bit mov_imm, mov_reg, alu_cls, is_cmp, is_mvn;
        ctl_t z;
        opc  = ir[15:13];
        op_f = ir[12:11];
        rn_f = ir[10:8];
        rd_f = ir[7:5];
        rm_f = ir[2:0];
        mov_imm = (opc == 3'b110) && (op_f == 2'b10);
        mov_reg = (opc == 3'b110) && (op_f == 2'b00);
        alu_cls = (opc == 3'b101);
        is_cmp  = alu_cls && op_f == 2'b01;
        is_mvn  = alu_cls && op_f == 2'b11;
        z = blank();
        z.bad = !(mov_imm || mov_reg || alu_cls);
        mq.push_back(z);                                   // decode cycle
        if (mov_imm) begin
            z = blank(); z.regnum = rn_f; z.vsel = 2'b01; z.write = 1'b1;
            mq.push_back(z);
        end else if (mov_reg || alu_cls) begin
            if (!(mov_reg || is_mvn)) begin
                z = blank(); z.regnum = rn_f; z.loada = 1'b1;
                mq.push_back(z);
            end
            z = blank(); z.regnum = rm_f; z.loadb = 1'b1;
            mq.push_back(z);
            z = blank();
            z.aluop = mov_reg ? 2'b00 : op_f;
            z.asel  = mov_reg || is_mvn;
            z.loads = is_cmp;
            z.loadc = !is_cmp;
            mq.push_back(z);
            if (!is_cmp) begin
                z = blank(); z.regnum = rd_f; z.write = 1'b1;
                mq.push_back(z);
            end
        end
    endfunction

    // Advance the model with the inputs seen at each rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_ir = 16'h0000;
            mq.delete();
        end else if (mq.size() == 0) begin
            if (load) m_ir = in_w;
            else if (s) schedule(m_ir);
        end else begin
            void'(mq.pop_front());
        end
    end

    function automatic ctl_t model_now();
        ctl_t e;
        if (mq.size() == 0) begin
            e = blank();
            e.w = 1'b1;
        end else begin
            e = mq[0];
        end
        e.shift  = m_ir[4:3];
        e.sximm8 = {{8{m_ir[7]}}, m_ir[7:0]};
        return e;
    endfunction

    function automatic ctl_t dut_now();
        ctl_t g;
        g.w = w; g.regnum = regnum; g.write = write;
        g.loada = loada; g.loadb = loadb; g.loadc = loadc; g.loads = loads;
        g.asel = asel; g.vsel = vsel; g.aluop = aluop; g.bad = bad;
        g.shift = shift; g.sximm8 = sximm8;
        return g;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            ctl_t e, g;
            e = model_now();
            g = dut_now();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL ctl_vector t=%0t got=%h required=%h", $time, g, e);
            end
            checks++;
            if (bsel !== 1'b0) begin
                failures++;
                $display("FAIL bsel t=%0t got=%b required=0", $time, bsel);
            end
        end
    end

    // ---------------- directed helpers ----------------
    ctl_t snaps[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Load an instruction, start it, record every cycle with w low
    task automatic run_instr(input logic [15:0] instr, output int lowc);
        load = 1'b1; in_w = instr; tick();
        load = 1'b0; s = 1'b1; tick();
        s = 1'b0;
        lowc = 0;
        snaps.delete();
        while (w == 1'b0 && lowc < 20) begin
            snaps.push_back(dut_now());
            lowc++;
            tick();
        end
        $display("instr %h: w low for %0d cycles", instr, lowc);
    endtask

    function automatic ctl_t snap(input int i);
        if (i < snaps.size()) return snaps[i];
        return blank();
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int lowc;
        int anyw;
        ctl_t c;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        lit("reset_w", int'(w), 1);
        lit("reset_write", int'(write), 0);
        lit("reset_sximm8", int'(sximm8), 0);

        // MOV R0,#7
        run_instr(16'hD007, lowc);
        lit("movimm_low", lowc, 2);
        c = snap(1);
        lit("movimm_regnum", int'(c.regnum), 0);
        lit("movimm_vsel", int'(c.vsel), 1);
        lit("movimm_write", int'(c.write), 1);
        lit("movimm_sximm8", int'(c.sximm8), 16'h0007);

        // MOV R1,#-8
        run_instr(16'hD1F8, lowc);
        c = snap(1);
        lit("movneg_sximm8", int'(c.sximm8), 16'hFFF8);
        lit("movneg_regnum", int'(c.regnum), 1);

        // ADD R2,R1,R0,LSL#1
        run_instr(16'hA148, lowc);
        lit("add_low", lowc, 5);
        c = snap(1); lit("add_geta_rn", int'(c.regnum), 1); lit("add_loada", int'(c.loada), 1);
        c = snap(2); lit("add_getb_rn", int'(c.regnum), 0); lit("add_loadb", int'(c.loadb), 1);
        lit("add_shift", int'(c.shift), 1);
        c = snap(3); lit("add_aluop", int'(c.aluop), 0); lit("add_loadc", int'(c.loadc), 1);
        c = snap(4); lit("add_wr_rn", int'(c.regnum), 2); lit("add_write", int'(c.write), 1);

        // CMP R1,R0
        run_instr(16'hA900, lowc);
        lit("cmp_low", lowc, 4);
        c = snap(3);
        lit("cmp_aluop", int'(c.aluop), 1);
        lit("cmp_loads", int'(c.loads), 1);
        lit("cmp_loadc", int'(c.loadc), 0);
        anyw = 0;
        foreach (snaps[i]) anyw = anyw | int'(snaps[i].write);
        lit("cmp_no_write", anyw, 0);

        // MOV R3,R1
        run_instr(16'hC061, lowc);
        lit("movreg_low", lowc, 4);
        c = snap(1); lit("movreg_getb_rn", int'(c.regnum), 1);
        c = snap(2); lit("movreg_asel", int'(c.asel), 1); lit("movreg_aluop", int'(c.aluop), 0);
        c = snap(3); lit("movreg_wr_rn", int'(c.regnum), 3);

        // Unsupported opcode
        run_instr(16'hE000, lowc);
        lit("bad_low", lowc, 1);
        c = snap(0);
        lit("bad_pulse", int'(c.bad), 1);
        lit("bad_enables", int'({c.write, c.loada, c.loadb, c.loadc, c.loads}), 0);
        lit("bad_after", int'(bad), 0);

        // load and s together: IR updates, sequencer stays idle
        load = 1'b1; s = 1'b1; in_w = 16'hD0AA; tick();
        lit("ls_w", int'(w), 1);
        lit("ls_sximm8", int'(sximm8), 16'hFFAA);
        load = 1'b0; s = 1'b0; tick();
        lit("ls_still_idle", int'(w), 1);

        // Reset while in GET_B
        load = 1'b1; in_w = 16'hA148; tick();
        load = 1'b0; s = 1'b1; tick();
        s = 1'b0; tick(); tick();
        lit("pre_reset_loadb", int'(loadb), 1);
        reset = 1'b1; tick();
        reset = 1'b0;
        lit("abort_w", int'(w), 1);
        lit("abort_enables", int'({write, loada, loadb, loadc, loads}), 0);

        // Randomized traffic checked cycle by cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r < 2);
            load  = (r >= 2 && r < 22);
            s     = ($urandom_range(0, 2) != 0);
            in_w  = rand_instr();
            tick();
        end
        reset = 1'b0; load = 1'b0; s = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srm_controller.md
# srm_controller

Instruction sequencer for the Simple RISC Machine datapath. It holds the instruction register and decodes MOV and ALU-class instructions. It drives the register-file, operand-register, status and ALU/shifter controls cycle by cycle, so that the datapath executes one instruction per start request. It sits between the external start/load interface and the datapath (register file, shifter, ALU, status register).

## Interface
Parameters:
- none. All encodings are fixed in `srm_pkg`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `s`  in  1  start request; sampled only in WAIT.
- `load`  in  1  instruction-register load enable; honoured only in WAIT.
- `in`  in  16  instruction word.
- `w`  out  1  idle/ready; 1 exactly while in WAIT.
- `regnum`  out  3  register-file read/write index for the current state.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for operand A, operand B, result C and status register.
- `asel`  out  1  1 = force ALU A input to 0.
- `bsel`  out  1  always 0 in this instruction set.
- `vsel`  out  2  writeback source: 00 = C, 01 = sximm8; other codes are never driven.
- `aluop`  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 not-B.
- `shift`  out  2  shifter code, taken from IR[4:3].
- `sximm8`  out  16  IR[7:0] sign-extended.
- `bad`  out  1  one-cycle pulse on an unsupported instruction.

## Operation
- IR fields are:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
  - imm8 = IR[7:0]
- Supported instructions:
  - 110/10 MOV Rn,#imm8.
  - 110/00 MOV Rd,Rm{,sh}.
  - 101/op ALU class, with aluop = op: ADD (00), CMP (01), AND (10), MVN (11).
- IR loading:
  - In WAIT with `load`=1, IR <= `in`.
  - `load` takes priority over `s` in the same cycle; `s` is then ignored.
  - `load` outside WAIT is ignored.
- States and transitions:
  - WAIT: on `s`=1 and `load`=0, go to DECODE.
  - DECODE: go to WR_IMM for MOV imm, GET_B for MOV reg or MVN, GET_A for ADD/AND/CMP. Any other opcode/op pulses `bad` and returns to WAIT.
  - WR_IMM → WAIT.
  - GET_A → GET_B → ALU.
  - ALU → WR_REG, except CMP, which goes ALU → WAIT.
  - WR_REG → WAIT.
- Per-state outputs (Moore: decoded from state + IR; every unlisted output is 0):
  - WR_IMM: regnum=Rn, vsel=01, write=1.
  - GET_A: regnum=Rn, loada=1.
  - GET_B: regnum=Rm, loadb=1.
  - ALU:
    - aluop: 00 for MOV reg, otherwise op.
    - asel=1 for MOV reg and MVN.
    - CMP: loads=1, loadc=0.
    - All other instructions: loadc=1, loads=0.
  - WR_REG: regnum=Rd, vsel=00, write=1.
- `shift` = sh in every state.
- `sximm8` is combinational from IR.
- Reset:
  - state <= WAIT, IR <= 0.
  - On the following cycle `w`=1 and every other control output is 0.
  - Reset asserted mid-instruction aborts it; no write occurs in the cycle after the reset edge.

## Timing
- Sampling `s` at edge E0 drops `w` from E0 onward. Cycles with `w` low:
  - MOV imm: 2.
  - MOV reg, MVN, CMP: 4.
  - ADD, AND: 5.
  - Unsupported instruction: 1 (DECODE, with `bad` high).
- Datapath registers capture on the edge that ends the state asserting their enable.
- `s` held high at the return to WAIT starts the next instruction after one cycle in WAIT (`w` high for ≥1 cycle).
- `write` is high for exactly one cycle per writing instruction.
- `loada`, `loadb`, `loadc`, `loads` are each high for at most one cycle per instruction.

## Structure
- `srm_pkg` holds:
  - state enum: WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG;
  - opcode/op constants;
  - aluop constants;
  - vsel codes;
  - IR field bit positions.
- Sub-module `instr_dec`: purely combinational IR → fields, sximm8, instruction class and legality.
- The FSM and IR register live in `srm_controller`.

## Test plan
- Reset, then load 0xD007 (MOV R0,#7) and pulse `s`:
  - WR_IMM shows regnum=0, vsel=01, write=1, sximm8=0x0007.
  - `w` low for exactly 2 cycles.
- Load 0xD1F8: sximm8=0xFFF8 and regnum=1 in WR_IMM.
- Load 0xA148 (ADD R2,R1,R0,LSL#1):
  - GET_A: regnum=1, loada=1.
  - GET_B: regnum=0, loadb=1, shift=01.
  - ALU: aluop=00, loadc=1.
  - WR_REG: regnum=2, write=1.
  - 5 cycles with `w` low.
- Load 0xA900 (CMP R1,R0):
  - ALU state has aluop=01, loads=1, loadc=0.
  - `write` never asserted.
  - Return to WAIT after 4 cycles.
- Load 0xC061 (MOV R3,R1):
  - GET_B regnum=1.
  - ALU: asel=1, aluop=00.
  - WR_REG: regnum=3.
- Invalid and corner cases:
  - Load 0xE000, pulse `s`: `bad`=1 for 1 cycle, back to WAIT, no load or write enables.
  - `load`=1 and `s`=1 together in WAIT: IR updates, state stays WAIT.
  - `reset` in GET_B: next cycle is WAIT with all enables 0.
